// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - two-channel write-back arbiter feeding the register-file write port
module rf_writeback_arbiter #(
   parameter int AWL        = 8,
   parameter int DWL        = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           a_valid,
   output logic           a_ready,
   input  logic [AWL-1:0] a_addr,
   input  logic [DWL-1:0] a_data,
   input  logic           b_valid,
   output logic           b_ready,
   input  logic [AWL-1:0] b_addr,
   input  logic [DWL-1:0] b_data,
   output logic           wen,
   output logic [AWL-1:0] WA,
   output logic [DWL-1:0] WD,
   output logic           b_starved
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   logic [7:0]     starve_cnt_q, starve_cnt_d;
   logic           wen_q, wen_d;
   logic [AWL-1:0] wa_q, wa_d;
   logic [DWL-1:0] wd_q, wd_d;
   logic           force_b;
   logic           a_xfer;
   logic           b_xfer;

   // Grant: A has fixed priority unless B has waited STARVE_MAX denied cycles.
   always_comb begin
      force_b   = b_valid && (starve_cnt_q == STARVE_LIM);
      a_ready   = a_valid && !force_b;
      b_ready   = b_valid && (!a_valid || force_b);
      b_starved = force_b;
      a_xfer    = a_valid && a_ready;
      b_xfer    = b_valid && b_ready;
   end

   // Next state: saturating starvation count and the one-cycle write register.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      wen_d        = 1'b0;
      wa_d         = wa_q;
      wd_d         = wd_q;

      if (!b_valid || b_xfer) begin
         starve_cnt_d = 8'd0;
      end else if (starve_cnt_q < STARVE_LIM) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end

      // Register 0 is hardwired to zero: the handshake completes but no write is emitted.
      if (a_xfer) begin
         wen_d = (a_addr != '0);
         wa_d  = a_addr;
         wd_d  = a_data;
      end else if (b_xfer) begin
         wen_d = (b_addr != '0);
         wa_d  = b_addr;
         wd_d  = b_data;
      end
   end

   // State register; reset clears the write strobe immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q <= 8'd0;
         wen_q        <= 1'b0;
         wa_q         <= '0;
         wd_q         <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         wen_q        <= wen_d;
         wa_q         <= wa_d;
         wd_q         <= wd_d;
      end
   end

   assign wen = wen_q;
   assign WA  = wa_q;
   assign WD  = wd_q;

endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Write-back arbiter placed directly upstream of the register file's single write port. Two result producers compete for that port: the single-cycle ALU path (channel A) and the variable-latency load/store path (channel B). The block accepts results over valid/ready handshakes and applies fixed priority to A, with a starvation guard for B. Each granted result goes out as one registered write (wen/WA/WD) on the following cycle. Writes to register 0 are accepted and discarded, because register 0 is hardwired to zero.

## Interface
- AWL, 8: register address width; must match the register file.
- DWL, 32: data width; must match the register file.
- STARVE_MAX, 4: number of consecutive denied cycles for B before B is forced to win; legal range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  ALU result present.
- a_ready  out  1  A accepted this cycle; combinational.
- a_addr  in  AWL  ALU destination register.
- a_data  in  DWL  ALU result.
- b_valid  in  1  load/store result present.
- b_ready  out  1  B accepted this cycle; combinational.
- b_addr  in  AWL  load/store destination register.
- b_data  in  DWL  load/store result.
- wen  out  1  register-file write enable; registered.
- WA  out  AWL  register-file write address; registered.
- WD  out  DWL  register-file write data; registered.
- b_starved  out  1  high in any cycle where B wins through the starvation guard; combinational.

## Operation
- **Transfer rule.** A transfer happens on a channel when valid && ready at a rising edge. Producers must hold addr/data stable while valid is high and ready is low.
- **Grant logic.** At most one channel is granted per cycle.
  - force_b = b_valid && (starve_cnt == STARVE_MAX).
  - a_ready = a_valid && !force_b.
  - b_ready = b_valid && (!a_valid || force_b).
  - b_starved = force_b.
- **Starvation counter.** starve_cnt is an 8-bit saturating counter.
  - It clears when b_valid is low or when B transfers.
  - It increments when b_valid is high and B is denied.
  - It never exceeds STARVE_MAX.
- **Output register.**
  - On an A transfer: wen <= (a_addr != 0), WA <= a_addr, WD <= a_data.
  - On a B transfer: the same, using the b_ fields.
  - With no transfer: wen <= 0. WA and WD hold their previous values.
- **Register 0.** A write to address 0 still completes the handshake (ready high). The producer is never stalled for it, and no write is emitted.
- **No back-pressure.** There is no back-pressure from the register file. Every granted transfer yields exactly one write cycle.
- **Output reset.** Reset clears wen=0, WA=0, WD=0 and starve_cnt=0 asynchronously. a_ready, b_ready and b_starved are then 0 whenever their valid inputs are 0.

## Timing
- **Latency.** A transfer at edge N produces wen/WA/WD during cycle N..N+1, and the register file commits it at edge N+1. Latency is 1 cycle.
- **Throughput.** One write per cycle sustained. Back-to-back grants produce back-to-back wen pulses with no bubble.
- **Worst-case wait for B.** B waits at most STARVE_MAX cycles after b_valid rises before it is granted, even with A valid continuously.
- **After a forced B grant.** The counter clears and A regains priority on the next cycle.
- **Same destination on both channels.** If A and B target the same register in consecutive grants, the later grant's data lands last. The arbiter performs no merging.
- **Reset during activity.** Asserting rst mid-stream clears wen immediately, without waiting for a clock edge. Any transfer completed at the edge coinciding with reset assertion is lost. After reset deassertion, the first edge behaves like a cold start with starve_cnt=0.

## Test plan
- **Reset.** Assert rst with both valids high. Required: wen=WA=WD=0 immediately; after release, the first edge grants A.
- **Single A write.** a_valid=1, a_addr=5, a_data=0xDEADBEEF for one cycle, B idle. Required: a_ready=1; next cycle wen=1, WA=5, WD=0xDEADBEEF; the cycle after, wen=0.
- **Register 0.** a_addr=0, a_data=0x1234. Required: a_ready=1; next cycle wen=0.
- **Contention without starvation.** A valid for 2 cycles and B valid throughout, with STARVE_MAX=4. Required: A granted in cycles 0–1, B granted in cycle 2; writes appear in the order A, A, B with no gap.
- **Starvation.** A and B both valid continuously, STARVE_MAX=4. Required:
  - B is denied for 4 cycles.
  - In the 5th cycle, b_starved=1 and b_ready=1.
  - The pattern repeats every 5 cycles: 4 A writes, then 1 B write.
- **Held data.** b_addr=7, b_data=0xA5A5A5A5 held while B waits. Required: the emitted write carries exactly those values once, and no duplicate write occurs.
